// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and an
// optional stall counter enabled by the IF_ID_PERF_CNT_EN macro.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal operation; a load-use hazard inserts one bubble
// STALL | bubble just issued; hazard ignored so each stall is one cycle

module if_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        instr_valid_in,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic        branch_taken,
  output logic [63:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        pc_write,
  output logic        bubble,
  output logic [31:0] stall_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t     state;
  logic [4:0] rn;
  logic [4:0] rm;
  logic [4:0] rt;
  logic       rt_src;
  logic       src_match;
  logic       hazard;

  assign rn = instr_out[9:5];
  assign rm = instr_out[20:16];
  assign rt = instr_out[4:0];

  // Rt is only read by STUR and CBZ
  assign rt_src = (instr_out[31:21] == 11'h7C0) || (instr_out[31:24] == 8'hB4);

  assign src_match = (idex_rd == rn) || (idex_rd == rm) || (rt_src && (idex_rd == rt));

  assign hazard = idex_memread && (idex_rd != 5'd31) && valid_out && src_match;

  // Reset and flush both suppress the bubble so the PC keeps advancing
  assign bubble   = rst && (state == RUN) && hazard && !branch_taken;
  assign pc_write = !bubble;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      pc_out    <= 64'h0;
      instr_out <= 32'h0;
      valid_out <= 1'b0;
    end else if (branch_taken) begin
      state     <= RUN;
      pc_out    <= pc_in;
      instr_out <= 32'h0;
      valid_out <= 1'b0;
    end else if (bubble) begin
      state     <= STALL;
    end else begin
      state     <= RUN;
      pc_out    <= pc_in;
      instr_out <= instr_in;
      valid_out <= instr_valid_in;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count_q <= 32'h0;
    end else if (bubble && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed corner cases then random traffic,
// checked against a cycle-level reference model of the pipeline register.

module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        idex_memread = 1'b0;
  logic [4:0]  idex_rd = '0;
  logic        branch_taken = 1'b0;
  logic [63:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        pc_write;
  logic        bubble;
  logic [31:0] stall_count;

  if_id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
    .instr_valid_in(instr_valid_in), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .branch_taken(branch_taken), .pc_out(pc_out),
    .instr_out(instr_out), .valid_out(valid_out), .pc_write(pc_write),
    .bubble(bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_regs;
    logic        bub;
    logic        pw;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        v;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: contents of the register after the most recent edge
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  bit          m_stalled = 0;
  logic [31:0] m_cnt;
  bit          m_known = 0;

  localparam logic [31:0] ADD_X3_X1_X2  = 32'h8B020023;
  localparam logic [31:0] ADD_X3_X31_X2 = 32'h8B0203E3;
  localparam logic [31:0] STUR_X5_X1    = 32'hF8000025;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("bubble", {63'h0, bubble}, {63'h0, e.bub});
      chk("pc_write", {63'h0, pc_write}, {63'h0, e.pw});
      if (e.chk_regs) begin
        chk("pc_out", pc_out, e.pc);
        chk("instr_out", {32'h0, instr_out}, {32'h0, e.instr});
        chk("valid_out", {63'h0, valid_out}, {63'h0, e.v});
        chk("stall_count", {32'h0, stall_count}, {32'h0, e.cnt});
      end
    end
  end

  // Does the instruction read register r as a source operand?
  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    bit uses_rt;
    uses_rt = (ins[31:21] == 11'h7C0) || (ins[31:24] == 8'hB4);
    return (ins[9:5] == r) || (ins[20:16] == r) || (uses_rt && ins[4:0] == r);
  endfunction

  task automatic drive(input logic r, input logic [63:0] pc, input logic [31:0] ins,
                       input logic iv, input logic mr, input logic [4:0] rd,
                       input logic br, input bit sat);
    exp_t e;
    bit   stall_now;
    @(posedge clk);
    #2;
    rst = r; pc_in = pc; instr_in = ins; instr_valid_in = iv;
    idex_memread = mr; idex_rd = rd; branch_taken = br;
`ifdef IF_ID_PERF_CNT_EN
    if (sat) begin
      force dut.stall_count_q = 32'hFFFF_FFFF;
      #1 release dut.stall_count_q;
      m_cnt = 32'hFFFF_FFFF;
    end
`endif
    stall_now = r && !m_stalled && !br && m_valid === 1'b1 && mr && rd != 5'd31
                && reads_reg(m_instr, rd);
    e.chk_regs = m_known;
    e.bub = stall_now;
    e.pw  = !stall_now;
    e.pc = m_pc; e.instr = m_instr; e.v = m_valid;
`ifdef IF_ID_PERF_CNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 32'h0;
`endif
    sb.push_back(e);
    if (!r) begin
      m_pc = '0; m_instr = '0; m_valid = 0; m_stalled = 0; m_cnt = '0; m_known = 1;
    end else if (br) begin
      m_pc = pc; m_instr = '0; m_valid = 0; m_stalled = 0;
    end else if (stall_now) begin
      m_stalled = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_pc = pc; m_instr = ins; m_valid = iv; m_stalled = 0;
    end
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 8);
    return (k == 8) ? 5'd31 : 5'(k);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0: rand_instr = x;
      1: rand_instr = {11'h458, pick_reg(), 6'h0, pick_reg(), pick_reg()};
      2: rand_instr = {11'h7C0, 11'h0, pick_reg(), pick_reg()};
      default: rand_instr = {8'hB4, x[23:5], pick_reg()};
    endcase
  endfunction

  initial begin
    // reset with arbitrary inputs
    drive(0, 64'hDEAD, 32'hFFFF_FFFF, 1, 1, 5'd1, 0, 0);
    drive(0, 64'hBEEF, ADD_X3_X1_X2, 1, 1, 5'd2, 0, 0);
    // load-use: stall one cycle, then released
    drive(1, 64'h100, ADD_X3_X1_X2, 1, 0, 5'd0, 0, 0);
    drive(1, 64'h104, 32'h1234_5678, 1, 1, 5'd1, 0, 0);
    drive(1, 64'h104, ADD_X3_X1_X2, 1, 1, 5'd1, 0, 0);
    // same hazard with branch: flush wins
    drive(1, 64'h200, ADD_X3_X1_X2, 1, 1, 5'd1, 1, 0);
    // STUR reads Rt
    drive(1, 64'h204, STUR_X5_X1, 1, 0, 5'd0, 0, 0);
    drive(1, 64'h208, STUR_X5_X1, 1, 1, 5'd5, 0, 0);
    drive(1, 64'h208, STUR_X5_X1, 1, 0, 5'd0, 0, 0);
    drive(1, 64'h20C, ADD_X3_X31_X2, 1, 1, 5'd6, 0, 0);
    // X31 never hazards
    drive(1, 64'h210, ADD_X3_X1_X2, 0, 1, 5'd31, 0, 0);
    // fetch bubble register never hazards
    drive(1, 64'h214, ADD_X3_X1_X2, 1, 1, 5'd1, 0, 0);
    // reset mid-stall then hazard again from RUN
    drive(1, 64'h218, ADD_X3_X1_X2, 1, 1, 5'd1, 0, 0);
    drive(0, 64'h21C, ADD_X3_X1_X2, 1, 1, 5'd1, 0, 0);
    drive(1, 64'h300, ADD_X3_X1_X2, 1, 0, 5'd0, 0, 0);
    drive(1, 64'h304, ADD_X3_X1_X2, 1, 1, 5'd2, 0, 0);
    drive(0, 64'h308, ADD_X3_X1_X2, 1, 1, 5'd2, 0, 0);
    drive(1, 64'h308, ADD_X3_X1_X2, 1, 1, 5'd1, 0, 0);
    // counter saturation (perf build only), hazard on the forced cycle
    drive(1, 64'h400, ADD_X3_X1_X2, 1, 0, 5'd0, 0, 0);
    drive(1, 64'h404, ADD_X3_X1_X2, 1, 1, 5'd1, 0, 1);
    drive(1, 64'h408, ADD_X3_X1_X2, 1, 1, 5'd1, 0, 0);
    drive(1, 64'h40C, ADD_X3_X1_X2, 1, 1, 5'd2, 0, 0);
    drive(0, 64'h0, 32'h0, 0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) != 0),
            {$urandom, $urandom},
            rand_instr(),
            ($urandom_range(0, 7) != 0),
            $urandom_range(0, 1) != 0,
            pick_reg(),
            ($urandom_range(0, 9) == 0),
            0);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state updates SHALL occur on the rising edge of clk.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1: pipeline clock.
- rst, in, 1: synchronous active-low reset.
- pc_in, in, 64: fetch-stage PC.
- instr_in, in, 32: fetched instruction.
- instr_valid_in, in, 1: fetch delivered a real instruction.
- idex_memread, in, 1: MemRead bit of the ID/EX stage's registered cntrl_M.
- idex_rd, in, 5: ID/EX stage's registered Rd.
- branch_taken, in, 1: branch resolved taken; the younger instruction must be flushed.
- pc_out, out, 64: registered PC.
- instr_out, out, 32: registered instruction.
- valid_out, out, 1: the registered instruction is real.
- pc_write, out, 1: enable for the PC register.
- bubble, out, 1: when 1, decode SHALL feed all-zero cntrl_EX, cntrl_M and cntrl_WB into ID/EX.
- stall_count, out, 32: load-use stall cycles counted (see Configuration).

Function
REQ-003 Latency SHALL be one cycle: on a load, pc_out, instr_out and valid_out SHALL take pc_in, instr_in and instr_valid_in at the next edge.
REQ-004 Source fields SHALL be taken from instr_out as follows: Rn = [9:5], Rm = [20:16], Rt = [4:0].
- Rt is a source only when instr_out[31:21] = 11'h7C0 (STUR) or instr_out[31:24] = 8'hB4 (CBZ).
REQ-005 hazard SHALL be 1 only when all of the following hold:
- idex_memread = 1;
- idex_rd != 5'd31;
- valid_out = 1;
- idex_rd equals Rn, or equals Rm, or equals Rt when Rt is a source.
REQ-006 The FSM SHALL have two states, RUN and STALL.
- RUN: bubble = hazard & ~branch_taken.
- STALL: bubble = 0, and hazard SHALL be ignored, limiting each load-use stall to exactly one cycle.
REQ-007 pc_write SHALL equal ~bubble (combinational).
REQ-008 FSM transitions SHALL be:
- RUN to STALL when bubble = 1;
- STALL to RUN unconditionally;
- RUN to RUN otherwise.
REQ-009 When bubble = 1, pc_out, instr_out and valid_out SHALL hold their values.
REQ-010 When branch_taken = 1, the next edge SHALL apply all of the following, regardless of state or hazard:
- valid_out <= 0, instr_out <= 32'h0, pc_out <= pc_in;
- state <= RUN.
REQ-011 In all other cycles the register SHALL load per REQ-003; instr_valid_in = 0 SHALL load valid_out = 0 (fetch bubble).
REQ-012 Simultaneous hazard and branch_taken: the flush SHALL win, so bubble = 0, pc_write = 1, and no stall is counted.
REQ-013 A register holding valid_out = 0 SHALL never raise hazard, whatever the contents of instr_out.

Reset
REQ-014 While rst = 0 at an edge, the block SHALL set all of the following:
- pc_out = 64'h0, instr_out = 32'h0, valid_out = 0;
- state = RUN, stall_count = 32'h0.
REQ-015 While rst = 0, pc_write SHALL be 1 and bubble SHALL be 0.
REQ-016 Reset asserted mid-stall SHALL abandon the stall; the first edge with rst = 1 SHALL behave as RUN.

Configuration
REQ-017 With macro IF_ID_PERF_CNT_EN defined:
- stall_count SHALL increment by 1 at each edge where bubble = 1 and rst = 1;
- stall_count SHALL saturate at 32'hFFFFFFFF.
REQ-018 Without IF_ID_PERF_CNT_EN:
- the stall_count port SHALL still exist and SHALL be tied to 32'h0;
- no counter flops SHALL be synthesised.

Verification
REQ-019 Reset: rst = 0 for 2 edges with arbitrary inputs -> the following hold:
- valid_out = 0, pc_out = 0, instr_out = 0, pc_write = 1, bubble = 0.
REQ-020 Load-use: all of the following hold:
- setup: instr_out = ADD X3,X1,X2 (32'h8B020023), valid_out = 1, idex_memread = 1, idex_rd = 1;
- cycle 0: bubble = 1, pc_write = 0;
- next edge: the register holds, state = STALL;
- following cycle: bubble = 0;
- stall_count = 1 when IF_ID_PERF_CNT_EN is defined.
REQ-021 X31 exemption: idex_memread = 1, idex_rd = 31, Rn = 31 -> bubble = 0.
REQ-022 Flush vs stall: hazard condition of REQ-020 plus branch_taken = 1 -> all of the following hold:
- bubble = 0, pc_write = 1;
- next edge: valid_out = 0, instr_out = 0;
- stall_count unchanged.
REQ-023 STUR source: all of the following hold:
- instr_out = 32'hF8000025 (STUR X5,[X1,#0]), idex_memread = 1, idex_rd = 5 -> bubble = 1;
- same test with idex_rd = 6 -> bubble = 0.
REQ-024 Saturation (IF_ID_PERF_CNT_EN defined): force stall_count = 32'hFFFFFFFF, then trigger a stall -> stall_count remains 32'hFFFFFFFF.
